// File: rtl/sar_search.sv
// rtl/sar_search.sv - successive-approximation search against an external comparator
// Optional macro SAR_SEARCH_EARLY_EXIT_EN: finish as soon as the comparator reports equal.
module sar_search #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_cmp_lower,
  input  logic             i_cmp_equal,
  input  logic             i_cmp_higher,
  output logic [WIDTH-1:0] o_trial,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_found
);

  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_TEST, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_trial;
  logic [WIDTH-1:0] r_result;
  logic [IW-1:0]    r_idx;
  logic             r_busy;
  logic             r_done;
  logic             r_found;

  logic             w_keep;
  logic [WIDTH-1:0] w_bit;
  logic [WIDTH-1:0] w_decided;

  // Equal beats lower beats higher; no assertion at all counts as higher.
  always_comb begin
    w_keep = 1'b0;
    if (i_cmp_equal)       w_keep = 1'b1;
    else if (i_cmp_lower)  w_keep = 1'b1;
    else if (i_cmp_higher) w_keep = 1'b0;
    w_bit     = WIDTH'(1) << r_idx;
    w_decided = w_keep ? r_trial : (r_trial & ~w_bit);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_trial  <= '0;
      r_result <= '0;
      r_idx    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_found  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_trial <= WIDTH'(1) << (WIDTH - 1);
            r_idx   <= IW'(WIDTH - 1);
            r_found <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_TEST;
          end
        end
        S_TEST: begin
`ifdef SAR_SEARCH_EARLY_EXIT_EN
          if (i_cmp_equal) begin
            r_result <= r_trial;
            r_found  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else
`endif
          begin
            if (i_cmp_equal) r_found <= 1'b1;
            if (r_idx == '0) begin
              r_trial  <= w_decided;
              r_result <= w_decided;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_trial <= w_decided | (w_bit >> 1);
              r_idx   <= r_idx - IW'(1);
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_trial  = r_trial;
  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_result = r_result;
  assign o_found  = r_found;

endmodule

// File: tb/tb_sar_search.sv
// tb/tb_sar_search.sv - directed bench for sar_search, WIDTH=8, comparator modelled from a half-unit target
module tb_sar_search;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       cmp_lower, cmp_equal, cmp_higher;
  logic [7:0] trial, result;
  logic       busy, done, found;

  int tx2;          // target times two, so x.5 targets can be expressed
  logic force_none;

  int errors = 0;
  int checks = 0;

  int seq_obs[16];
  int seq_len;
  int lat;
  int extra_done;

  sar_search #(.WIDTH(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .i_cmp_lower(cmp_lower), .i_cmp_equal(cmp_equal), .i_cmp_higher(cmp_higher),
    .o_trial(trial), .o_busy(busy), .o_done(done), .o_result(result), .o_found(found)
  );

  always #5 clk = ~clk;

  always_comb begin
    cmp_lower  = 1'b0;
    cmp_equal  = 1'b0;
    cmp_higher = 1'b0;
    if (!force_none) begin
      cmp_lower  = (int'(trial) * 2) < tx2;
      cmp_equal  = (int'(trial) * 2) == tx2;
      cmp_higher = (int'(trial) * 2) > tx2;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pulse start, then log trials each busy cycle until done or a 30-cycle bound.
  task automatic run(input int t2, input int force_step, input int start_step);
    tx2 = t2;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    seq_len = 0;
    while (!done && lat < 30) begin
      force_none = (seq_len == force_step) && busy;
      start = (seq_len == start_step) && busy;
      if (busy) begin
        seq_obs[seq_len] = int'(trial);
        seq_len++;
      end
      @(negedge clk);
      lat++;
    end
    force_none = 1'b0;
    start = 1'b0;
    check("done_within_bound", {31'd0, done}, 32'd1);
  endtask

  task automatic watch_no_done(input int cycles);
    extra_done = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (done || busy) extra_done++;
    end
  endtask

  initial begin
    int exp_seq[8];
    int exp_len;
    int exp_lat;
    exp_seq = '{128, 64, 96, 112, 104, 100, 102, 101};
`ifdef SAR_SEARCH_EARLY_EXIT_EN
    exp_len = 6;
    exp_lat = 7;
`else
    exp_len = 8;
    exp_lat = 9;
`endif
    rst_n = 1'b0;
    start = 1'b1;
    force_none = 1'b0;
    tx2 = 200;
    repeat (3) @(negedge clk);
    check("rst_trial", 32'(trial), 0);
    check("rst_result", 32'(result), 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_found", {31'd0, found}, 0);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_start", {31'd0, busy}, 0);

    // target 100
    run(200, -1, -1);
    check("t100_len", seq_len, exp_len);
    for (int i = 0; i < 8; i++)
      if (i < exp_len) check($sformatf("t100_trial%0d", i), seq_obs[i], exp_seq[i]);
    check("t100_latency", lat, exp_lat);
    check("t100_result", 32'(result), 100);
    check("t100_found", {31'd0, found}, 1);
    @(negedge clk);
    check("t100_done_one_cycle", {31'd0, done}, 0);
    check("t100_result_held", 32'(result), 100);

    // target 0: trial never reaches 0, so equal is never seen
    run(0, -1, -1);
    check("t0_latency", lat, 9);
    check("t0_result", 32'(result), 0);
    check("t0_found", {31'd0, found}, 0);

    // target 255
    run(510, -1, -1);
    check("t255_latency", lat, 9);
    check("t255_result", 32'(result), 255);
    check("t255_found", {31'd0, found}, 1);
    check("t255_trial_held", 32'(trial), 255);

    // target 200, no comparator input on the first step: bit 7 cleared
    run(400, 0, -1);
    check("none_trial1", seq_obs[1], 64);
    check("none_result", 32'(result), 127);
    check("none_found", {31'd0, found}, 0);

    // target 77.5, start pulsed mid-search
    run(155, -1, 3);
    check("t77_latency", lat, 9);
    check("t77_result", 32'(result), 77);
    check("t77_found", {31'd0, found}, 0);
    watch_no_done(12);
    check("t77_no_extra_done", extra_done, 0);
    check("t77_trial_held", 32'(trial), 77);

    // reset in the 4th TEST cycle
    tx2 = 200;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", {31'd0, busy}, 1);
    rst_n = 1'b0;
    start = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_trial", 32'(trial), 0);
    check("mid_rst_result", 32'(result), 0);
    check("mid_rst_done", {31'd0, done}, 0);
    rst_n = 1'b1;
    start = 1'b0;
    watch_no_done(12);
    check("post_rst_quiet", extra_done, 0);

    run(200, -1, -1);
    check("after_rst_latency", lat, exp_lat);
    check("after_rst_result", 32'(result), 100);
    check("after_rst_found", {31'd0, found}, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
